// File: rtl/io_bus_arbiter_if.sv
// Requester-side handshake bundle for io_bus_arbiter: two requesters sharing one
// read-data return and a busy flag.
interface io_bus_arbiter_if;
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [7:0]  wdata0;
    logic        ack0;
    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [7:0]  wdata1;
    logic        ack1;
    logic [7:0]  rdata;
    logic        busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, ack1, rdata, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter for two requesters in front of an 8-bit I/O bus with
// separate active-low read/write strobes; one 5-cycle bus transaction per grant.
module io_bus_arbiter (
    input  logic            clock,
    input  logic            reset_,
    io_bus_arbiter_if.slave req_if,
    output logic [15:0]     addr,
    inout  wire  [7:0]      data,
    output logic            ior_,
    output logic            iow_
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        STRB1 = 3'd2,
        STRB2 = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t      state_q;
    logic        gnt_q;
    logic        last_q;
    logic        we_q;
    logic        drive_q;
    logic        ior_q;
    logic        iow_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        busy_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        gnt_d;
    logic        any_req_s;

    assign any_req_s = req_if.req0 | req_if.req1;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        gnt_d = 1'b0;
        if (req_if.req0 && req_if.req1) begin
            gnt_d = ~last_q;
        end else if (req_if.req1) begin
            gnt_d = 1'b1;
        end else begin
            gnt_d = 1'b0;
        end
    end

    // Transaction sequencer; every bus-facing output is a register set one edge ahead.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            drive_q <= 1'b0;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_s) begin
                        gnt_q   <= gnt_d;
                        we_q    <= gnt_d ? req_if.we1    : req_if.we0;
                        drive_q <= gnt_d ? req_if.we1    : req_if.we0;
                        addr_q  <= gnt_d ? req_if.addr1  : req_if.addr0;
                        wdata_q <= gnt_d ? req_if.wdata1 : req_if.wdata0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SETUP: begin
                    ior_q   <= we_q;
                    iow_q   <= ~we_q;
                    state_q <= STRB1;
                end
                STRB1: begin
                    state_q <= STRB2;
                end
                STRB2: begin
                    ior_q  <= 1'b1;
                    iow_q  <= 1'b1;
                    last_q <= gnt_q;
                    // ior_ is still low at this edge, so the peripheral's byte is valid.
                    if (!we_q) begin
                        rdata_q <= data;
                    end else begin
                        rdata_q <= rdata_q;
                    end
                    if (gnt_q) begin
                        ack1_q <= 1'b1;
                    end else begin
                        ack0_q <= 1'b1;
                    end
                    state_q <= HOLD;
                end
                HOLD: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    drive_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ior_q   <= 1'b1;
                    iow_q   <= 1'b1;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    drive_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data         = drive_q ? wdata_q : 8'hZZ;
    assign addr         = addr_q;
    assign ior_         = ior_q;
    assign iow_         = iow_q;
    assign req_if.ack0  = ack0_q;
    assign req_if.ack1  = ack1_q;
    assign req_if.rdata = rdata_q;
    assign req_if.busy  = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: queued requesters, a peripheral answering read strobes,
// a phase-count reference model compared every cycle, and directed scenario checks.
module tb_io_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_;
    logic [15:0] addr;
    wire  [7:0]  data;
    logic        ior_;
    logic        iow_;
    logic [7:0]  bus_val;

    io_bus_arbiter_if ifc ();

    io_bus_arbiter dut (
        .clock  (clock),
        .reset_ (reset_),
        .req_if (ifc),
        .addr   (addr),
        .data   (data),
        .ior_   (ior_),
        .iow_   (iow_)
    );

    // Peripheral returns bus_val while the read strobe is active; released bus floats high.
    assign data = (ior_ == 1'b0) ? bus_val : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data[g]);
    end

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   pop0 = 1'b0;
    bit   pop1 = 1'b0;
    bit   scramble = 1'b0;
    bit   prev_busy = 1'b0;
    int   ior_low_n, iow_low_n, c3_n;
    int   ack_who[$];
    int   ack_cyc[$];
    int   setup_cyc[$];

    // Reference model: a transaction is 4 busy phases (1..4) after the IDLE grant cycle.
    int          m_phase;
    logic        m_gnt, m_last, m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wd, m_rdata;
    wire         m_pick = (ifc.req0 && ifc.req1) ? ~m_last : ifc.req1;

    function automatic txn_t mk(input logic we, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we;
        t.a  = a;
        t.d  = d;
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic clear_log();
        ior_low_n = 0;
        iow_low_n = 0;
        c3_n      = 0;
        ack_who.delete();
        ack_cyc.delete();
        setup_cyc.delete();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_phase != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s timeout: actual still busy, required idle", name);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            m_phase <= 0;
            m_gnt   <= 1'b0;
            m_last  <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= 16'h0000;
            m_wd    <= 8'h00;
            m_rdata <= 8'h00;
        end else if (m_phase == 0) begin
            if (ifc.req0 || ifc.req1) begin
                m_gnt   <= m_pick;
                m_we    <= m_pick ? ifc.we1 : ifc.we0;
                m_addr  <= m_pick ? ifc.addr1 : ifc.addr0;
                m_wd    <= m_pick ? ifc.wdata1 : ifc.wdata0;
                m_phase <= 1;
            end
        end else if (m_phase == 4) begin
            m_last  <= m_gnt;
            m_phase <= 0;
        end else begin
            if (m_phase == 3 && !m_we) m_rdata <= bus_val;
            m_phase <= m_phase + 1;
        end
    end

    // Requesters: hold the head of the queue on the bus, retire it after its ack.
    always @(posedge clock) begin
        #1;
        if (pop0) begin
            if (q0.size() != 0) q0.delete(0);
            pop0 = 1'b0;
        end
        if (pop1) begin
            if (q1.size() != 0) q1.delete(0);
            pop1 = 1'b0;
        end
        if (q0.size() != 0) begin
            ifc.req0   = 1'b1;
            ifc.we0    = q0[0].we;
            ifc.addr0  = (scramble && m_phase != 0 && !m_gnt) ? q0[0].a + 16'd1 : q0[0].a;
            ifc.wdata0 = (scramble && m_phase != 0 && !m_gnt) ? ~q0[0].d : q0[0].d;
        end else begin
            ifc.req0 = 1'b0;
        end
        if (q1.size() != 0) begin
            ifc.req1   = 1'b1;
            ifc.we1    = q1[0].we;
            ifc.addr1  = q1[0].a;
            ifc.wdata1 = q1[0].d;
        end else begin
            ifc.req1 = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin : cmp
        logic       strb;
        logic [7:0] exp_d;
        strb = (m_phase == 2) || (m_phase == 3);
        if (m_phase != 0 && m_we)  exp_d = m_wd;
        else if (strb && !m_we)    exp_d = bus_val;
        else                       exp_d = 8'hFF;
        check("busy",  16'(ifc.busy),  16'(m_phase != 0));
        check("ior_",  16'(ior_),      16'(!(strb && !m_we)));
        check("iow_",  16'(iow_),      16'(!(strb && m_we)));
        check("ack0",  16'(ifc.ack0),  16'(m_phase == 4 && !m_gnt));
        check("ack1",  16'(ifc.ack1),  16'(m_phase == 4 && m_gnt));
        check("addr",  addr,           m_addr);
        check("rdata", 16'(ifc.rdata), 16'(m_rdata));
        check("data",  16'(data),      16'(exp_d));
        if (!ior_) ior_low_n++;
        if (!iow_) begin
            iow_low_n++;
            if (data == 8'hC3) c3_n++;
        end
        if (ifc.busy && !prev_busy) setup_cyc.push_back(cyc);
        prev_busy = ifc.busy;
        if (ifc.ack0) begin pop0 = 1'b1; ack_who.push_back(0); ack_cyc.push_back(cyc); end
        if (ifc.ack1) begin pop1 = 1'b1; ack_who.push_back(1); ack_cyc.push_back(cyc); end
    end

    initial begin
        int n, seen, bad;
        reset_ = 1'b0;
        ifc.req0 = 1'b0; ifc.we0 = 1'b0; ifc.addr0 = 16'h0000; ifc.wdata0 = 8'h00;
        ifc.req1 = 1'b0; ifc.we1 = 1'b0; ifc.addr1 = 16'h0000; ifc.wdata1 = 8'h00;
        bus_val = 8'h00;
        clear_log();
        repeat (3) @(negedge clock);
        #1;
        check("rst_addr",  addr, 16'h0000);
        check("rst_ior",   16'(ior_), 16'd1);
        check("rst_iow",   16'(iow_), 16'd1);
        check("rst_busy",  16'(ifc.busy), 16'd0);
        check("rst_rdata", 16'(ifc.rdata), 16'h0000);
        check("rst_data",  16'(data), 16'h00FF);
        @(posedge clock); #1 reset_ = 1'b1;

        // Read from requester 0.
        clear_log();
        bus_val = 8'h5A;
        q0.push_back(mk(1'b0, 16'h0120, 8'h00));
        wait_done("read");
        check("rd_rdata",   16'(ifc.rdata), 16'h005A);
        check("rd_ior_low", 16'(ior_low_n), 16'd2);
        check("rd_iow_low", 16'(iow_low_n), 16'd0);
        check("rd_ack_who", 16'(ack_who[0]), 16'd0);
        check("rd_latency", 16'(ack_cyc[0] - (setup_cyc[0] - 1)), 16'd4);

        // Write from requester 1.
        clear_log();
        q1.push_back(mk(1'b1, 16'h0140, 8'hC3));
        wait_done("write");
        check("wr_iow_low", 16'(iow_low_n), 16'd2);
        check("wr_c3",      16'(c3_n), 16'd2);
        check("wr_ior_low", 16'(ior_low_n), 16'd0);
        check("wr_ack_who", 16'(ack_who[0]), 16'd1);
        check("wr_data_z",  16'(data), 16'h00FF);
        check("wr_rdata",   16'(ifc.rdata), 16'h005A);

        // Tie straight after reset.
        @(posedge clock); #1 reset_ = 1'b0;
        @(posedge clock); #1 reset_ = 1'b1;
        clear_log();
        q0.push_back(mk(1'b0, 16'h0010, 8'h00));
        q1.push_back(mk(1'b1, 16'h0020, 8'h11));
        wait_done("tie");
        check("tie_n",    16'(ack_who.size()), 16'd2);
        check("tie_1st",  16'(ack_who[0]), 16'd0);
        check("tie_2nd",  16'(ack_who[1]), 16'd1);
        check("tie_gap",  16'(ack_cyc[1] - ack_cyc[0]), 16'd5);

        // Fairness under continuous requests.
        clear_log();
        q0.push_back(mk(1'b1, 16'h0030, 8'h21));
        q0.push_back(mk(1'b0, 16'h0031, 8'h00));
        q1.push_back(mk(1'b0, 16'h0040, 8'h00));
        q1.push_back(mk(1'b1, 16'h0041, 8'h42));
        wait_done("fair");
        check("fair_n", 16'(ack_who.size()), 16'd4);
        for (int i = 0; i < 4; i++) begin
            check("fair_who", 16'(ack_who[i]), 16'(i % 2));
        end
        for (int i = 1; i < 4; i++) begin
            check("fair_gap", 16'(ack_cyc[i] - ack_cyc[i-1]), 16'd5);
        end

        // Requester 0 changes its fields after the grant.
        clear_log();
        scramble = 1'b1;
        q0.push_back(mk(1'b0, 16'h0100, 8'h00));
        n = 0; seen = 0; bad = 0;
        while ((q0.size() != 0 || m_phase != 0) && n < 50) begin
            @(negedge clock);
            n++;
            if (ifc.busy) begin
                seen++;
                if (addr !== 16'h0100) bad++;
            end
        end
        scramble = 1'b0;
        check("stab_busy_cycles", 16'(seen), 16'd4);
        check("stab_addr_bad",    16'(bad), 16'd0);

        // Reset abort during the first write strobe cycle, with requester 0 pending.
        clear_log();
        bus_val = 8'h77;
        q1.push_back(mk(1'b1, 16'h0200, 8'h3C));
        n = 0;
        while (!ifc.busy && n < 20) begin @(negedge clock); n++; end
        q0.push_back(mk(1'b0, 16'h0300, 8'h00));
        n = 0;
        while (iow_ && n < 20) begin @(negedge clock); n++; end
        check("abort_reached_strobe", 16'(iow_), 16'd0);
        #2 reset_ = 1'b0;
        #1;
        check("abort_iow",  16'(iow_), 16'd1);
        check("abort_ior",  16'(ior_), 16'd1);
        check("abort_data", 16'(data), 16'h00FF);
        check("abort_ack1", 16'(ifc.ack1), 16'd0);
        check("abort_busy", 16'(ifc.busy), 16'd0);
        @(posedge clock); #1 reset_ = 1'b1;
        ack_who.delete();
        ack_cyc.delete();
        wait_done("abort");
        check("abort_n",     16'(ack_who.size()), 16'd2);
        check("abort_1st",   16'(ack_who[0]), 16'd0);
        check("abort_2nd",   16'(ack_who[1]), 16'd1);
        check("abort_rdata", 16'(ifc.rdata), 16'h0077);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required done)");
        $fatal(1, "watchdog");
    end

endmodule
